booth_mult_16: RTL

- Iterative signed 16x16 multiplier producing a 32-bit two's-complement product.
- Radix-2 Booth, one add/sub-and-shift step per clock.
- Sits directly downstream of, and wraps, the existing 16-bit ripple-carry adder, which performs every partial-product add/subtract.
- Serves the processor's multdiv path: start/ready handshake, result held until next accepted start.

---
 rtl/mult_pkg.sv | 15 +
 rtl/rca_16bit.sv | 24 ++
 rtl/booth_mult_16.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared encodings and sizing for the iterative Booth multiplier.
// Pure declarations: no logic, no latency, no handshake.
package mult_pkg;

  localparam int MULT_WIDTH = 16;
  localparam int MULT_ITERS = 16;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mult_state_e;

endpackage

// File: rtl/rca_16bit.sv
// 16-bit ripple-carry adder with carry-out and signed-overflow flag.
// Purely combinational, no handshake; carry ripples LSB to MSB.
module rca_16bit (
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic        ci,
  output logic [15:0] sum,
  output logic        co,
  output logic        ovf
);

  logic [16:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign sum[i]   = in1[i] ^ in2[i] ^ c[i];
    assign c[i + 1] = (in1[i] & in2[i]) | (c[i] & (in1[i] ^ in2[i]));
  end

  assign co  = c[16];
  assign ovf = c[16] ^ c[15];

endmodule

// File: rtl/booth_mult_16.sv
// Radix-2 Booth signed 16x16 multiplier, one step per clock, 17 cycles start-to-result.
// start is accepted only while ready (IDLE/DONE); product and ovf hold until the next completion.
module booth_mult_16
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int ITERS = MULT_ITERS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               result_rdy,
  output logic [2*WIDTH-1:0] product,
  output logic               ovf
);

  mult_state_e        state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   adder_in2;
  logic               adder_ci;
  logic [WIDTH-1:0]   adder_sum;
  logic               adder_ovf;
  logic               adder_co_unused;
  logic               do_arith;
  logic [WIDTH-1:0]   s;
  logic               sgn;
  logic [WIDTH:0]     p_hi;

  rca_16bit u_adder (
    .in1 (a_q),
    .in2 (adder_in2),
    .ci  (adder_ci),
    .sum (adder_sum),
    .co  (adder_co_unused),
    .ovf (adder_ovf)
  );

  always_comb begin
    adder_in2 = m_q;
    adder_ci  = 1'b0;
    do_arith  = 1'b0;
    case ({q_q[0], qm1_q})
      2'b01: do_arith = 1'b1;
      2'b10: begin
        adder_in2 = ~m_q;
        adder_ci  = 1'b1;
        do_arith  = 1'b1;
      end
      default: ;
    endcase
    s   = do_arith ? adder_sum : a_q;
    // True 17-bit sign of A+/-M, so M = -32768 needs no wider accumulator.
    sgn = do_arith ? (adder_sum[WIDTH-1] ^ adder_ovf) : a_q[WIDTH-1];
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    p_hi      = '0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = {sgn, s[WIDTH-1:1]};
        q_d   = {s[0], q_q[WIDTH-1:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d   = DONE;
          product_d = {a_d, q_d};
          p_hi      = product_d[2*WIDTH-1:WIDTH-1];
          ovf_d     = !((&p_hi) || !(|p_hi));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ready      = (state_q != RUN);
  assign result_rdy = (state_q == DONE);
  assign product    = product_q;
  assign ovf        = ovf_q;

endmodule
